multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS-subset datapath. It steps each instruction through four states: fetch, decode, execute and write-back. It handshakes with instruction memory, applies the per-opcode ALU and register-file controls only in the cycles where they are valid, and counts retired instructions. It sits between the instruction memory interface and the shared ALU / register-file datapath. It replaces single-cycle decode when the datapath is shared across cycles.

---
 rtl/multicycle_ctrl_if.sv | 21 ++
 rtl/multicycle_ctrl.sv | 147 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Instruction-memory handshake between the multi-cycle sequencer and the fetch unit.
// mem_req_o/mem_ack_i form a request/acknowledge pair; instr_op_i is the opcode field of the fetched instruction.
interface multicycle_ctrl_if;
  logic       mem_req_o;
  logic       mem_ack_i;
  logic [5:0] instr_op_i;

  // Handshake: the sequencer holds mem_req_o high in FETCH until it samples mem_ack_i=1 on a
  // rising edge; mem_ack_i is ignored whenever mem_req_o is low.
  modport master (
    output mem_req_o,
    input  mem_ack_i,
    input  instr_op_i
  );

  modport slave (
    input  mem_req_o,
    output mem_ack_i,
    output instr_op_i
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Four-phase (FETCH/DECODE/EXEC/WB) control sequencer for a shared MIPS-subset datapath.
// Drives ALU/register-file controls only in EXEC/WB and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  multicycle_ctrl_if.master imem,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic [2:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             mem_req;
  logic             ir_write;
  logic             pc_write;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic             reg_dst;
  logic             reg_write;
  logic             illegal;
  logic             in_legal;
  logic [4:0]       op_ctrl;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI);
  endfunction

  // Packed as {ALUOp[2:0], ALUSrc, RegDst}.
  function automatic logic [4:0] op_controls(input logic [5:0] op);
    logic [4:0] ctl;
    ctl = 5'b000_0_0;
    case (op)
      OP_RTYPE: ctl = 5'b010_0_1;
      OP_ADDI:  ctl = 5'b100_1_0;
      OP_SLTI:  ctl = 5'b101_1_0;
      default:  ctl = 5'b000_0_0;
    endcase
    return ctl;
  endfunction

  assign in_legal = op_legal(imem.instr_op_i);
  assign op_ctrl  = op_controls(op_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= 6'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retired_d = retired_q;
    mem_req   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    alu_op    = 3'b000;
    alu_src   = 1'b0;
    reg_dst   = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        // IR load and PC advance follow the ack in the same cycle.
        if (imem.mem_ack_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        op_d = imem.instr_op_i;
        if (in_legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_EXEC: begin
        {alu_op, alu_src, reg_dst} = op_ctrl;
        state_d = ST_WB;
      end

      ST_WB: begin
        {alu_op, alu_src, reg_dst} = op_ctrl;
        reg_write = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = en_i ? ST_FETCH : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem.mem_req_o = mem_req;
  assign IRWrite_o      = ir_write;
  assign PCWrite_o      = pc_write;
  assign ALUOp_o        = alu_op;
  assign ALUSrc_o       = alu_src;
  assign RegDst_o       = reg_dst;
  assign RegWrite_o     = reg_write;
  assign illegal_o      = illegal;
  assign state_o        = state_q;
  assign retired_o      = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-plus-random bench for multicycle_ctrl (CNT_W=4) with a per-cycle reference model
// built from the opcode table and the phase rules of the sequencer.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_i;
  logic       IRWrite_o, PCWrite_o, ALUSrc_o, RegDst_o, RegWrite_o, illegal_o;
  logic [2:0] ALUOp_o;
  logic [2:0] state_o;
  logic [3:0] retired_o;

  int tests   = 0;
  int fails   = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .imem       (mif.master),
    .IRWrite_o  (IRWrite_o),
    .PCWrite_o  (PCWrite_o),
    .ALUOp_o    (ALUOp_o),
    .ALUSrc_o   (ALUSrc_o),
    .RegDst_o   (RegDst_o),
    .RegWrite_o (RegWrite_o),
    .illegal_o  (illegal_o),
    .state_o    (state_o),
    .retired_o  (retired_o)
  );

  // Reference opcode table: {ALUOp, ALUSrc, RegDst}.
  function automatic bit ref_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h08) || (op == 6'h0a);
  endfunction

  function automatic logic [4:0] ref_ctl(input logic [5:0] op);
    if (op == 6'h00) return 5'b01001;
    if (op == 6'h08) return 5'b10010;
    if (op == 6'h0a) return 5'b10110;
    return 5'b00000;
  endfunction

  function automatic logic [17:0] obs_vec();
    return {state_o, mif.mem_req_o, IRWrite_o, PCWrite_o, ALUOp_o, ALUSrc_o, RegDst_o,
            RegWrite_o, illegal_o, retired_o};
  endfunction

  function automatic logic [17:0] exp_vec(input int st, input bit req, input bit irw,
                                          input logic [4:0] ctl, input bit rw, input bit ill);
    return {3'(st), req, irw, irw, ctl, rw, ill, 4'(exp_ret)};
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%05h expected=0x%05h", tag, obs, exp);
    end
  endtask

  // One instruction from its first FETCH cycle; optionally reset asynchronously in EXEC.
  task automatic do_instr(input logic [5:0] op, input int delay, input bit en_wb, input bit abort);
    logic [4:0] ctl;
    ctl = ref_ctl(op);
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      en_i           = 1'($urandom_range(0, 1));
      mif.mem_ack_i  = (k == delay);
      mif.instr_op_i = 6'($urandom);
      #1 chk("fetch", obs_vec(), exp_vec(1, 1'b1, (k == delay), 5'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    en_i           = 1'($urandom_range(0, 1));
    mif.mem_ack_i  = 1'($urandom_range(0, 1));
    mif.instr_op_i = op;
    #1 chk("decode", obs_vec(), exp_vec(2, 1'b0, 1'b0, 5'b0, 1'b0, !ref_legal(op)));
    if (!ref_legal(op)) return;
    @(negedge clk);
    en_i           = en_wb;
    mif.mem_ack_i  = 1'($urandom_range(0, 1));
    mif.instr_op_i = 6'($urandom);
    #1 chk("exec", obs_vec(), exp_vec(3, 1'b0, 1'b0, ctl, 1'b0, 1'b0));
    if (abort) begin
      #2 rst_i = 1'b0;
      exp_ret = 0;
      #1 chk("rst_async", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
      repeat (2) begin
        @(negedge clk);
        #1 chk("rst_hold", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      rst_i = 1'b1;
      en_i  = 1'b1;
      #1 chk("rst_release", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
      return;
    end
    @(negedge clk);
    en_i = en_wb;
    #1 chk("wb", obs_vec(), exp_vec(4, 1'b0, 1'b0, ctl, 1'b1, 1'b0));
    exp_ret = (exp_ret + 1) % 16;
    if (!en_wb) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        en_i = 1'b0;
        #1 chk("idle_hold", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
      end
      @(negedge clk);
      en_i = 1'b1;
      #1 chk("idle_restart", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
    end
  endtask

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    int sel;
    logic [5:0] op;
    sel = allow_illegal ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
    case (sel)
      0:       op = 6'h00;
      1:       op = 6'h08;
      2:       op = 6'h0a;
      default: begin
        op = 6'($urandom);
        if (ref_legal(op)) op = 6'h3f;
      end
    endcase
    return op;
  endfunction

  initial begin
    rst_i          = 1'b0;
    en_i           = 1'b1;
    mif.mem_ack_i  = 1'b0;
    mif.instr_op_i = 6'h00;

    // Reset held for three cycles with en_i high, then released.
    repeat (3) begin
      @(negedge clk);
      #1 chk("reset", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst_i = 1'b1;
    #1 chk("post_reset", obs_vec(), exp_vec(0, 1'b0, 1'b0, 5'b0, 1'b0, 1'b0));

    do_instr(6'h00, 0, 1'b1, 1'b0);   // R-type, immediate ack
    do_instr(6'h08, 3, 1'b1, 1'b0);   // addi, three wait cycles
    do_instr(6'h3f, 0, 1'b1, 1'b0);   // illegal
    do_instr(6'h0a, 0, 1'b1, 1'b0);   // slti

    // Sixteen legal back-to-back instructions wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) do_instr(rand_op(1'b0), $urandom_range(0, 2), 1'b1, 1'b0);

    for (int i = 0; i < 40; i++)
      do_instr(rand_op(1'b1), $urandom_range(0, 3), ($urandom_range(0, 3) != 0), 1'b0);

    do_instr(6'h00, 0, 1'b0, 1'b0);   // enable dropped in EXEC
    do_instr(6'h08, 1, 1'b1, 1'b1);   // reset mid-EXEC
    do_instr(6'h0a, 0, 1'b0, 1'b0);   // recovery after reset

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
